// File: rtl/cfg_pkg.sv
// Shared constants, tile field layout and loader state encoding.
package cfg_pkg;

  localparam int unsigned CFG_W       = 77;
  localparam int unsigned FRAME_BYTES = 10;
  localparam int unsigned FRAME_W     = FRAME_BYTES * 8;
  localparam int unsigned BYTE_CNT_W  = 4;

  // Tile field offsets within the 77-bit config word
  localparam int unsigned CLB_MSB = 76;
  localparam int unsigned CLB_LSB = 54;
  localparam int unsigned CBL_MSB = 53;
  localparam int unsigned CBL_LSB = 36;
  localparam int unsigned CTR_MSB = 35;
  localparam int unsigned CTR_LSB = 18;
  localparam int unsigned S_MSB   = 17;
  localparam int unsigned S_LSB   = 0;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    CHK,
    DONE,
    ERR
  } loader_state_e;

endpackage

// File: rtl/cfg_frame_shifter.sv
// Byte-serial frame assembler: MSB-first shift register plus byte counter.
module cfg_frame_shifter
  import cfg_pkg::*;
#(
  parameter int unsigned CFG_W = cfg_pkg::CFG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift_en,
  input  logic [7:0]       din,
  output logic [CFG_W-1:0] cfg_bits,
  output logic             frame_full,
  output logic             pad_ok
);

  // Only the low 72 bits are kept; the frame including the incoming byte
  // is presented combinationally so the loader can latch it on the same edge.
  logic [FRAME_W-9:0]    frame;
  logic [FRAME_W-1:0]    frame_next;
  logic [BYTE_CNT_W-1:0] byte_cnt;

  // Frame as it will look after the current byte is shifted in
  always_comb begin
    frame_next = {frame, din};
    cfg_bits   = frame_next[CFG_W-1:0];
    pad_ok     = (frame_next[FRAME_W-1:CFG_W] == '0);
    frame_full = shift_en && (byte_cnt == BYTE_CNT_W'(FRAME_BYTES - 1));
  end

  // Shift register and byte counter, counter wraps after the last byte
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      frame    <= '0;
      byte_cnt <= '0;
    end else if (shift_en) begin
      frame <= frame_next[FRAME_W-9:0];
      if (frame_full) byte_cnt <= '0;
      else            byte_cnt <= byte_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cfg_loader.sv
// Bitstream loader: assembles per-tile config frames, strobes them onto the
// shared tile bus and verifies a trailing XOR checksum byte.
module cfg_loader
  import cfg_pkg::*;
#(
  parameter int unsigned NUM_TILES = 4,
  parameter int unsigned CFG_W     = cfg_pkg::CFG_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [7:0]           din,
  input  logic                 din_valid,
  output logic                 din_ready,
  output logic [CFG_W-1:0]     tile_bits,
  output logic [NUM_TILES-1:0] tile_wr_en,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int unsigned IDX_W = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;

  loader_state_e        state, state_next;
  logic [IDX_W-1:0]     tile_idx;
  logic [7:0]           csum;
  logic                 load_accept;
  logic                 chk_accept;
  logic                 restart;
  logic                 last_tile;
  logic                 frame_full;
  logic                 pad_ok;
  logic [CFG_W-1:0]     cfg_bits;
  logic [NUM_TILES-1:0] tile_sel;

  cfg_frame_shifter #(.CFG_W(CFG_W)) u_shifter (
    .clk        (clk),
    .rst        (rst),
    .clear      (restart),
    .shift_en   (load_accept),
    .din        (din),
    .cfg_bits   (cfg_bits),
    .frame_full (frame_full),
    .pad_ok     (pad_ok)
  );

  // Next-state logic; outputs are registered from the next state so they
  // line up with the state they describe
  always_comb begin
    state_next  = state;
    load_accept = din_valid && din_ready && (state == LOAD);
    chk_accept  = din_valid && din_ready && (state == CHK);
    restart     = start && ((state == IDLE) || (state == DONE) || (state == ERR));
    last_tile   = (tile_idx == IDX_W'(NUM_TILES - 1));
    tile_sel    = '0;
    tile_sel[tile_idx] = 1'b1;
    case (state)
      IDLE, DONE, ERR: if (restart) state_next = LOAD;
      LOAD:  if (frame_full) state_next = pad_ok ? WRITE : ERR;
      WRITE: state_next = last_tile ? CHK : LOAD;
      CHK:   if (chk_accept) state_next = (din == csum) ? DONE : ERR;
      default: state_next = IDLE;
    endcase
  end

  // State, tile index, checksum and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tile_idx   <= '0;
      csum       <= '0;
      din_ready  <= 1'b0;
      tile_bits  <= '0;
      tile_wr_en <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state <= state_next;

      if (restart) begin
        tile_idx <= '0;
        csum     <= '0;
      end else begin
        if (load_accept) csum <= csum ^ din;
        if ((state == WRITE) && !last_tile) tile_idx <= tile_idx + 1'b1;
      end

      din_ready <= (state_next == LOAD) || (state_next == CHK);
      busy      <= (state_next == LOAD) || (state_next == WRITE) || (state_next == CHK);
      done      <= (state_next == DONE);
      err       <= (state_next == ERR);

      if (state_next == WRITE) begin
        tile_bits  <= cfg_bits;
        tile_wr_en <= tile_sel;
      end else begin
        tile_wr_en <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cfg_loader.sv
// Directed self-checking bench for cfg_loader with two tiles.
module tb_cfg_loader;

  localparam int unsigned NT = 2;
  localparam int unsigned CW = 77;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [7:0]    din;
  logic          din_valid;
  logic          din_ready;
  logic [CW-1:0] tile_bits;
  logic [NT-1:0] tile_wr_en;
  logic          busy;
  logic          done;
  logic          err;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;

  localparam logic [79:0] FR_ONES = 80'h1FFF_FFFF_FFFF_FFFF_FFFF;
  localparam logic [79:0] FR_ZERO = 80'h0;
  localparam logic [79:0] FR_PAD  = 80'h2000_0000_0000_0000_0000;
  localparam logic [CW-1:0] BITS_ONES = 77'h1FFF_FFFF_FFFF_FFFF_FFFF;

  cfg_loader #(.NUM_TILES(NT), .CFG_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .tile_bits  (tile_bits),
    .tile_wr_en (tile_wr_en),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Count cycles with any write strobe active
  always @(negedge clk) if (tile_wr_en != '0) wr_count++;

  // Present one byte, hold until accepted; returns at posedge+1 of acceptance
  task automatic send_byte(input logic [7:0] b, input int gap);
    int cnt;
    cnt = 0;
    din = b;
    din_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (din_ready) break;
      cnt++;
      if (cnt > 50) begin
        checks++; errors++;
        $display("FAIL send_byte timeout: din_ready=%b required 1", din_ready);
        din_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    din_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
    end
  endtask

  // Send a 10-byte frame MSB first; returns #1 after the 10th accept edge
  task automatic send_frame(input logic [79:0] fr, input int gap, input int nbytes);
    for (int i = 0; i < nbytes; i++) begin
      send_byte(fr[79-8*i -: 8], (i == nbytes - 1) ? 0 : gap);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Full two-tile load; checks both strobes and the trailer outcome
  task automatic run_load(input string tag, input int gap, input logic [7:0] trailer,
                          input logic exp_done);
    int wc0;
    wc0 = wr_count;
    pulse_start();
    checks++;
    if (busy !== 1'b1 || din_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s start: busy=%b din_ready=%b required 1/1", tag, busy, din_ready);
    end
    send_frame(FR_ONES, gap, 10);
    checks++;
    if (tile_wr_en !== 2'b01 || tile_bits !== BITS_ONES) begin
      errors++;
      $display("FAIL %s tile0: wr_en=%b bits=%h required 01/%h", tag, tile_wr_en, tile_bits, BITS_ONES);
    end
    send_frame(FR_ZERO, gap, 10);
    checks++;
    if (tile_wr_en !== 2'b10 || tile_bits !== '0) begin
      errors++;
      $display("FAIL %s tile1: wr_en=%b bits=%h required 10/0", tag, tile_wr_en, tile_bits);
    end
    send_byte(trailer, 0);
    checks++;
    if (done !== exp_done || err !== ~exp_done || busy !== 1'b0 || din_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s result: done=%b err=%b busy=%b ready=%b required %b/%b/0/0",
               tag, done, err, busy, din_ready, exp_done, ~exp_done);
    end
    checks++;
    if (wr_count - wc0 !== 2) begin
      errors++;
      $display("FAIL %s strobe_count: %0d required 2", tag, wr_count - wc0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (tile_bits !== '0 || tile_wr_en !== '0 || din_ready !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset: bits=%h wr_en=%b ready=%b busy=%b done=%b err=%b required all 0",
               tile_bits, tile_wr_en, din_ready, busy, done, err);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || din_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle: busy=%b ready=%b required 0/0", busy, din_ready);
    end
  endtask

  task automatic test_good_load();
    run_load("good", 0, 8'hE0, 1'b1);
  endtask

  task automatic test_bad_csum();
    run_load("bad_csum", 0, 8'hE1, 1'b0);
  endtask

  task automatic test_pad_error();
    int wc0;
    wc0 = wr_count;
    pulse_start();
    checks++;
    if (err !== 1'b0 || din_ready !== 1'b1) begin
      errors++;
      $display("FAIL pad restart: err=%b ready=%b required 0/1", err, din_ready);
    end
    send_frame(FR_PAD, 0, 10);
    checks++;
    if (err !== 1'b1 || done !== 1'b0 || tile_wr_en !== '0 || busy !== 1'b0 || din_ready !== 1'b0) begin
      errors++;
      $display("FAIL pad: err=%b done=%b wr_en=%b busy=%b ready=%b required 1/0/00/0/0",
               err, done, tile_wr_en, busy, din_ready);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (wr_count !== wc0 || err !== 1'b1) begin
      errors++;
      $display("FAIL pad hold: strobes=%0d err=%b required 0/1", wr_count - wc0, err);
    end
  endtask

  task automatic test_stall();
    run_load("stall", 1, 8'hE0, 1'b1);
  endtask

  task automatic test_reset_mid_load();
    pulse_start();
    send_frame(FR_ONES, 0, 5);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || din_ready !== 1'b0 || tile_wr_en !== '0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b ready=%b wr_en=%b required 0/0/00", busy, din_ready, tile_wr_en);
    end
    rst = 1'b0;
    run_load("after_reset", 0, 8'hE0, 1'b1);
  endtask

  task automatic test_start_mid_load();
    int wc0;
    wc0 = wr_count;
    pulse_start();
    send_frame(FR_ONES, 0, 4);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || din_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_start: busy=%b ready=%b required 1/1", busy, din_ready);
    end
    for (int i = 4; i < 10; i++) send_byte(FR_ONES[79-8*i -: 8], 0);
    checks++;
    if (tile_wr_en !== 2'b01 || tile_bits !== BITS_ONES) begin
      errors++;
      $display("FAIL mid_start tile0: wr_en=%b bits=%h required 01/%h", tile_wr_en, tile_bits, BITS_ONES);
    end
    send_frame(FR_ZERO, 0, 10);
    send_byte(8'hE0, 0);
    checks++;
    if (done !== 1'b1 || err !== 1'b0 || wr_count - wc0 !== 2) begin
      errors++;
      $display("FAIL mid_start result: done=%b err=%b strobes=%0d required 1/0/2", done, err, wr_count - wc0);
    end
    pulse_start();
    checks++;
    if (done !== 1'b0 || din_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_from_done: done=%b ready=%b busy=%b required 0/1/1", done, din_ready, busy);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    din = '0;
    din_valid = 1'b0;
    test_reset();
    test_good_load();
    test_bad_csum();
    test_pad_error();
    test_stall();
    test_reset_mid_load();
    test_start_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cfg_loader.md
Name: cfg_loader

Overview:
Configuration loader sitting directly upstream of the tile array. It accepts a byte-serial bitstream over a valid/ready handshake and assembles one 77-bit configuration frame per tile. It drives each frame onto the shared tile config bus with a one-cycle per-tile write enable, then checks an XOR trailer byte. It reports busy/done/err to the host.

Parameters:
NUM_TILES, 4, number of tiles loaded in order 0..NUM_TILES-1.
CFG_W, 77, config bits per tile; fixed by tile layout.
FRAME_BYTES, 10, derived ceil(CFG_W/8); not overridable.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle pulse that begins a load
din  in  8  bitstream byte
din_valid  in  1  din holds a byte
din_ready  out  1  loader accepts a byte this cycle
tile_bits  out  CFG_W  config bus shared by all tiles
tile_wr_en  out  NUM_TILES  one-hot write strobe, bit i = tile i
busy  out  1  load in progress
done  out  1  load completed, checksum good
err  out  1  pad or checksum failure

Behaviour:
- Reset values: tile_bits=0, tile_wr_en=0, din_ready=0, busy=0, done=0, err=0, state=IDLE. All outputs are registered.
- States:
  - IDLE: start -> LOAD; tile_idx=0, byte_cnt=0, csum=0.
  - LOAD: din_ready=1. A byte is accepted on a clk edge with din_valid&&din_ready. Accepting it updates frame<={frame[71:0],din}, csum^=din, byte_cnt++.
  - LOAD exit: on the 10th byte, byte_cnt wraps to 0. If new frame[79:77]!=0 -> ERR, otherwise -> WRITE.
  - WRITE: exactly one cycle. tile_bits=frame[76:0] and tile_wr_en=1<<tile_idx are both valid this cycle. Next: if tile_idx==NUM_TILES-1 -> CHK, else tile_idx++ -> LOAD.
  - CHK: din_ready=1. On accept, if din==csum -> DONE, else -> ERR. The trailer byte is not folded into csum.
  - DONE: done=1. ERR: err=1. Both hold until start, which re-enters LOAD with counters cleared and done/err cleared.
- Byte order: first byte is most significant; bits 79:77 of byte 0 are pad and must be 0.
- Latency: 10th frame byte accepted at edge N -> WRITE strobe during cycle N+1 -> LOAD or CHK at N+2. Minimum 11 cycles per tile.
- tile_bits holds its last value after WRITE. Tiles sample only while their wr_en is high.
- busy=1 in LOAD, WRITE and CHK.
- start is ignored while busy; a mid-load start does not restart.
- din_valid low stalls with no timeout. Bytes presented outside LOAD/CHK are not accepted (din_ready=0).
- Reset mid-load returns to IDLE the next cycle with wr_en=0. Tiles already written keep their contents.
- On a checksum error, tiles are already written; err only flags the failure and the host must reload.

Decomposition:
- Shared package cfg_pkg:
  - CFG_W=77, FRAME_BYTES=10.
  - Tile field offsets: CLB [76:54], bottom-left C [53:36], top-right C [35:18], S [17:0].
  - Loader state enum {IDLE, LOAD, WRITE, CHK, DONE, ERR}.
- One natural sub-module, cfg_frame_shifter: the 80-bit byte shift register plus byte counter. It exposes frame_full and pad_ok. The FSM, tile index and checksum stay in cfg_loader.

Test Plan:
- NUM_TILES=2, start. Tile0 = 0x1F then nine 0xFF; tile1 = ten 0x00; trailer 0xE0. Required: tile_wr_en=2'b01 with tile_bits=77'h1FFF_FFFF_FFFF_FFFF_FFFF. Then 2'b10 with tile_bits=0. Then done=1, err=0.
- Same stream with trailer 0xE1 -> both tiles written, then err=1, done=0.
- Byte 0 of tile0 = 0x20 (pad bit set) -> ERR after the 10th byte, tile_wr_en never asserted.
- din_valid toggled every other cycle -> identical strobes and values as the first test, each WRITE one cycle after its 10th accepted byte.
- rst asserted after 5 bytes of tile0 -> next cycle busy=0, din_ready=0, tile_wr_en=0. A new start then a full stream -> correct load.
- start pulsed mid-LOAD -> ignored, load completes normally. start in DONE -> done clears and din_ready=1 next cycle.
